// File: rtl/conv_pkg.sv
// Shared convolutional-code definitions.
// Holds the default code parameters (rate, constraint length, data word width,
// generator taps), the trellis state width shared with the Viterbi decoder,
// and the encoder FSM encoding.
// No ports.
package conv_pkg;

    localparam int unsigned CONV_R = 2;   // code symbols per input bit
    localparam int unsigned CONV_K = 3;   // constraint length
    localparam int unsigned CONV_W = 8;   // input data word width

    // Polynomial j occupies G[K*(j+1)-1:K*j]: j0 = 7 octal, j1 = 5 octal.
    localparam logic [CONV_R*CONV_K-1:0] CONV_G = 6'b101_111;

    // Trellis state width; the decoder indexes its path metrics with this.
    localparam int unsigned NS_BITS = CONV_K - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_fsm_e;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the convolutional encoder (purely combinational).
// The tap window is {b, enc_state}; bit K-1 of each polynomial taps the new
// bit, bit k < K-1 taps enc_state[k]. The newest bit enters at the MSB of
// the state, so state s has predecessors {s[K-3:0], x}, matching the decoder.
// Ports:
//   b          - input bit
//   enc_state  - current encoder state (K-1 bits)
//   sym        - code symbol, sym[j] = output of polynomial j
//   next_state - state after shifting b in
module conv_enc_step
    import conv_pkg::*;
#(
    parameter int unsigned          R = CONV_R,
    parameter int unsigned          K = CONV_K,
    parameter logic [R*K-1:0]       G = CONV_G
) (
    input  logic             b,
    input  logic [K-2:0]     enc_state,
    output logic [R-1:0]     sym,
    output logic [K-2:0]     next_state
);

    logic [K-1:0] window;

    always_comb begin
        window = {b, enc_state};
        sym    = '0;
        for (int j = 0; j < int'(R); j++) begin
            sym[j] = ^(window & G[K*j +: K]);
        end
    end

    generate
        if (K == 2) begin : g_k2
            assign next_state = b;
        end else begin : g_kn
            assign next_state = {b, enc_state[K-2:1]};
        end
    endgenerate

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/R, constraint-length-K convolutional encoder.
// Accepts W-bit words on a valid/ready handshake, serialises them LSB-first
// and emits one R-bit code symbol per bit through a single output register.
// Every frame is closed with K-1 zero tail bits so the trellis ends in state 0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no word held; ready for the first word of a frame
// DATA  | encoding word_q[bit_cnt_q]; may take the next word on the last bit
// TAIL  | flushing K-1 zero bits; sym_last marks the final tail symbol
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready - word input handshake
//   sym/sym_valid/sym_last/sym_ready  - code symbol output handshake
module conv_encoder
    import conv_pkg::*;
#(
    parameter int unsigned    R = CONV_R,
    parameter int unsigned    K = CONV_K,
    parameter int unsigned    W = CONV_W,
    parameter logic [R*K-1:0] G = CONV_G
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [R-1:0] sym,
    output logic         sym_valid,
    output logic         sym_last,
    input  logic         sym_ready
);

    localparam int unsigned NS   = K - 1;
    localparam int unsigned BC_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned TC_W = ($clog2(K) < 1) ? 1 : $clog2(K);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(W - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(K - 2);

    enc_fsm_e        state_q;
    logic [NS-1:0]   enc_state_q;
    logic [NS-1:0]   enc_state_d;
    logic [BC_W-1:0] bit_cnt_q;
    logic [TC_W-1:0] tail_cnt_q;
    logic [W-1:0]    word_q;
    logic            last_q;

    logic            adv;
    logic            bit_last;
    logic            enc_bit;
    logic            accept;
    logic [R-1:0]    sym_d;

    conv_enc_step #(
        .R (R),
        .K (K),
        .G (G)
    ) u_step (
        .b          (enc_bit),
        .enc_state  (enc_state_q),
        .sym        (sym_d),
        .next_state (enc_state_d)
    );

    // Output register advances when empty or being drained this cycle.
    always_comb begin
        adv      = !sym_valid || sym_ready;
        bit_last = (bit_cnt_q == BC_LAST);
        enc_bit  = (state_q == DATA) ? word_q[bit_cnt_q] : 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            // Take the next word of the frame on the last data bit so the
            // first bit of the new word follows without a bubble.
            DATA:    in_ready = adv && bit_last && !last_q;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            enc_state_q <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            sym         <= '0;
            sym_valid   <= 1'b0;
            sym_last    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adv) begin
                        sym_valid <= 1'b0;
                        sym_last  <= 1'b0;
                    end
                    if (accept) begin
                        word_q    <= in_data;
                        last_q    <= in_last;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (adv) begin
                        sym         <= sym_d;
                        sym_valid   <= 1'b1;
                        sym_last    <= 1'b0;
                        enc_state_q <= enc_state_d;
                        if (bit_last) begin
                            bit_cnt_q <= '0;
                            if (last_q) begin
                                tail_cnt_q <= '0;
                                state_q    <= TAIL;
                            end else if (accept) begin
                                word_q <= in_data;
                                last_q <= in_last;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (adv) begin
                        sym         <= sym_d;
                        sym_valid   <= 1'b1;
                        enc_state_q <= enc_state_d;
                        tail_cnt_q  <= tail_cnt_q + 1'b1;
                        if (tail_cnt_q == TC_LAST) begin
                            sym_last <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder (K=3, r=2, G = 7,5 octal, W=8).
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_last;
    logic       sym_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0] words [8];
    logic [1:0] got_sym[$];
    bit         got_last[$];
    int         sym_cyc[$];
    int         acc_cyc[$];
    int         stable_err;
    int         ready_err;
    bit         timed_out;
    logic [1:0] exp_q[$];

    conv_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_last  (sym_last),
        .sym_ready (sym_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives nw words from words[] (last flag on the final one) and collects
    // symbols until sym_last is consumed, stop_after symbols are consumed, or
    // the cycle budget runs out. sym_ready is dropped with stall_pct percent.
    task automatic run_frame(input int nw, input int stall_pct, input int stop_after);
        int         wi = 0;
        int         cyc = 0;
        bit         done = 0;
        bit         prev_stall = 0;
        logic [1:0] prev_sym = '0;
        got_sym.delete(); got_last.delete(); sym_cyc.delete(); acc_cyc.delete();
        stable_err = 0;
        ready_err  = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            sym_ready = ($urandom_range(99) >= stall_pct);
            if (wi < nw) begin
                in_valid = 1'b1;
                in_data  = words[wi];
                in_last  = (wi == nw - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
                in_last  = 1'b0;
            end
            #1;
            if (prev_stall && (sym !== prev_sym || sym_valid !== 1'b1)) stable_err++;
            if (sym_valid && !sym_ready && in_ready && got_sym.size() < nw * 8) ready_err++;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                wi++;
            end
            if (sym_valid && sym_ready) begin
                got_sym.push_back(sym);
                got_last.push_back(sym_last);
                sym_cyc.push_back(cyc);
                if (sym_last || got_sym.size() == stop_after) done = 1;
            end
            prev_stall = sym_valid && !sym_ready;
            prev_sym   = sym;
            cyc++;
        end
        timed_out = !done;
    endtask

    task automatic check_seq(input string tag, input logic [1:0] exp[$], input bit with_tail);
        check({tag, "_len"}, got_sym.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_sym.size(); i++) begin
            check($sformatf("%s_sym%0d", tag, i), got_sym[i], exp[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i],
                  with_tail && (i == exp.size() - 1));
        end
    endtask

    initial begin
        logic [1:0] exp_01[$];
        logic [1:0] exp_ff[$];
        logic [1:0] exp_b2b[$];
        logic       s1, s0, b;
        int         dec_err;

        exp_01  = '{2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_ff  = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        exp_b2b = '{2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; sym_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sym_valid", sym_valid, 1'b0);
        check("rst_sym", sym, 2'b00);
        check("rst_sym_last", sym_last, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;

        // Single word 0x01
        words[0] = 8'h01;
        run_frame(1, 0, 0);
        check("w01_timeout", timed_out, 1'b0);
        check_seq("w01", exp_01, 1'b1);
        @(negedge clk);
        check("w01_end_state", dut.enc_state_q, 2'b00);

        // Single word 0xFF
        words[0] = 8'hFF;
        run_frame(1, 0, 0);
        check("wff_timeout", timed_out, 1'b0);
        check_seq("wff", exp_ff, 1'b1);

        // Back-to-back words within one frame
        words[0] = 8'h01; words[1] = 8'h00;
        run_frame(2, 0, 0);
        check("b2b_timeout", timed_out, 1'b0);
        check_seq("b2b", exp_b2b, 1'b1);
        check("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2 && sym_cyc.size() == 18) begin
            check("b2b_accept_at_bit7", acc_cyc[1], sym_cyc[7] - 1);
            check("b2b_no_bubble", sym_cyc[17] - sym_cyc[0], 17);
        end

        // 0xFF with random back-pressure
        words[0] = 8'hFF;
        run_frame(1, 50, 0);
        check("stall_timeout", timed_out, 1'b0);
        check_seq("stall", exp_ff, 1'b1);
        check("stall_sym_stable", stable_err, 0);
        check("stall_no_in_ready", ready_err, 0);

        // Reset in the middle of a frame
        @(negedge clk);
        words[0] = 8'h01;
        run_frame(1, 0, 3);
        check_seq("pre_rst", '{2'd3, 2'd1, 2'd3}, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sym_valid", sym_valid, 1'b0);
        check("mid_rst_sym", sym, 2'b00);
        check("mid_rst_sym_last", sym_last, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        run_frame(1, 0, 0);
        check("post_rst_timeout", timed_out, 1'b0);
        check_seq("post_rst", exp_01, 1'b1);

        // Multi-word frame against a reference shift-register encoder,
        // then hard-decision inversion back to the source bits.
        words[0] = 8'($urandom); words[1] = 8'($urandom); words[2] = 8'($urandom);
        exp_q.delete();
        s1 = 1'b0; s0 = 1'b0;
        for (int i = 0; i < 26; i++) begin
            b = (i < 24) ? words[i / 8][i % 8] : 1'b0;
            exp_q.push_back({b ^ s0, b ^ s1 ^ s0});
            s0 = s1; s1 = b;
        end
        run_frame(3, 30, 0);
        check("rand_timeout", timed_out, 1'b0);
        check_seq("rand", exp_q, 1'b1);
        check("rand_sym_stable", stable_err, 0);
        dec_err = 0;
        s1 = 1'b0; s0 = 1'b0;
        for (int i = 0; i < got_sym.size(); i++) begin
            b = got_sym[i][0] ^ s1 ^ s0;
            if (got_sym[i][1] !== (b ^ s0)) dec_err++;
            if (b !== ((i < 24) ? words[i / 8][i % 8] : 1'b0)) dec_err++;
            s0 = s1; s1 = b;
        end
        check("rand_decode", dec_err, 0);
        check("rand_trellis_end", {s1, s0}, 2'b00);
        @(negedge clk);
        check("rand_end_state", dut.enc_state_q, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
